hazard_unit: RTL and testbench

//  Consumer of the datapath's Match_* forwarding-compare outputs and the control unit's PC-write/branch/memtoreg flags.

---
 rtl/hazard_unit.sv | 111 +++++++++++
 tb/tb_hazard_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding selects, load-use stall and R15-write flush tracking.
// Optional HAZARD_PERF_EN adds saturating stall/flush/load-use event counters.
module hazard_unit #(
  parameter bit          FWD_EN = 1'b1,
  parameter int unsigned CNT_W  = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Match_1E_M,
  input  logic       Match_1E_W,
  input  logic       Match_2E_M,
  input  logic       Match_2E_W,
  input  logic       Match_12D_E,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       PCSrcD,
  input  logic       BranchTakenE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushD,
  output logic       FlushE
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] ldr_cnt
`endif
);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {IDLE, PC_E, PC_M, PC_W} state_t;

  if (CNT_W == 0) begin : g_bad_cnt_w
    $error("hazard_unit: CNT_W must be at least 1");
  end

  state_t state;
  logic   ldr_stall;
  logic   pcsrc_q;
  logic   pc_wr_pending;

  assign ldr_stall     = Match_12D_E & MemtoRegE;
  // A PC writer that is stalled or on a squashed path never reaches Writeback.
  assign pcsrc_q       = PCSrcD & ~ldr_stall & ~BranchTakenE;
  assign pc_wr_pending = pcsrc_q | (state == PC_E) | (state == PC_M);

  // R15-write tracker: follows the writer from Execute down to Writeback.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    state <= pcsrc_q ? PC_E : IDLE;
        PC_E:    state <= PC_M;
        PC_M:    state <= PC_W;
        PC_W:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Forwarding selects and stall/flush enables; reset forces bubbles everywhere.
  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    StallF    = 1'b0;
    StallD    = 1'b0;
    FlushD    = 1'b1;
    FlushE    = 1'b1;
    if (!reset) begin
      if (FWD_EN) begin
        if (Match_1E_M & RegWriteM)      ForwardAE = FWD_MEM;
        else if (Match_1E_W & RegWriteW) ForwardAE = FWD_WB;
        if (Match_2E_M & RegWriteM)      ForwardBE = FWD_MEM;
        else if (Match_2E_W & RegWriteW) ForwardBE = FWD_WB;
      end
      StallF = ldr_stall | pc_wr_pending;
      // A taken branch squashes Decode, so it overrides any load-use hold.
      StallD = ldr_stall & ~BranchTakenE;
      FlushD = pc_wr_pending | (state == PC_W) | BranchTakenE;
      FlushE = ldr_stall | BranchTakenE;
    end
  end

`ifdef HAZARD_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturating event counters, one edge behind the event.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      ldr_cnt   <= '0;
    end else begin
      if (StallF && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if ((FlushD || FlushE) && flush_cnt != CNT_MAX)
        flush_cnt <= flush_cnt + CNT_W'(1);
      if (ldr_stall && ldr_cnt != CNT_MAX)
        ldr_cnt <= ldr_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit: forwarding priority, load-use stall,
// R15-write tracking, branch flush, illegal overlap and mid-sequence reset.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E;
  logic       RegWriteM, RegWriteW, MemtoRegE, PCSrcD, BranchTakenE;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, FlushD, FlushE;
  logic [1:0] nf_fwd_a, nf_fwd_b;
  logic       nf_stall_f, nf_stall_d, nf_flush_d, nf_flush_e;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt, ldr_cnt;
  logic [31:0] nf_stall_cnt, nf_flush_cnt, nf_ldr_cnt;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Control vector {StallF, StallD, FlushD, FlushE}
  logic [3:0] ctl;
  assign ctl = {StallF, StallD, FlushD, FlushE};

  always #5 clk = ~clk;

  hazard_unit #(.FWD_EN(1'b1), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .Match_1E_M(Match_1E_M), .Match_1E_W(Match_1E_W),
    .Match_2E_M(Match_2E_M), .Match_2E_W(Match_2E_W),
    .Match_12D_E(Match_12D_E), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .PCSrcD(PCSrcD), .BranchTakenE(BranchTakenE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .ldr_cnt(ldr_cnt)
`endif
  );

  hazard_unit #(.FWD_EN(1'b0), .CNT_W(32)) dut_nofwd (
    .clk(clk), .reset(reset),
    .Match_1E_M(Match_1E_M), .Match_1E_W(Match_1E_W),
    .Match_2E_M(Match_2E_M), .Match_2E_W(Match_2E_W),
    .Match_12D_E(Match_12D_E), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .PCSrcD(PCSrcD), .BranchTakenE(BranchTakenE),
    .ForwardAE(nf_fwd_a), .ForwardBE(nf_fwd_b),
    .StallF(nf_stall_f), .StallD(nf_stall_d), .FlushD(nf_flush_d), .FlushE(nf_flush_e)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(nf_stall_cnt), .flush_cnt(nf_flush_cnt), .ldr_cnt(nf_ldr_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_inputs();
    Match_1E_M = 1'b0; Match_1E_W = 1'b0; Match_2E_M = 1'b0; Match_2E_W = 1'b0;
    Match_12D_E = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0; MemtoRegE = 1'b0;
    PCSrcD = 1'b0; BranchTakenE = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] t4_ctl [5];
    t4_ctl[0] = 4'b1010;  // IDLE with PC writer in Decode
    t4_ctl[1] = 4'b1010;  // PC_E
    t4_ctl[2] = 4'b1010;  // PC_M
    t4_ctl[3] = 4'b0010;  // PC_W
    t4_ctl[4] = 4'b0000;  // back to IDLE

    // Reset state, with hazards present on the inputs
    clr_inputs();
    reset = 1'b1;
    Match_1E_M = 1'b1; RegWriteM = 1'b1; Match_2E_W = 1'b1; RegWriteW = 1'b1;
    Match_12D_E = 1'b1; MemtoRegE = 1'b1; PCSrcD = 1'b1;
    #1;
    check("rst ForwardAE", 32'(ForwardAE), 32'h0);
    check("rst ForwardBE", 32'(ForwardBE), 32'h0);
    check("rst ctl", 32'(ctl), 32'b0011);
    tick();
    tick();
    reset = 1'b0;
    clr_inputs();
    #1;
    check("idle ctl", 32'(ctl), 32'b0000);
`ifdef HAZARD_PERF_EN
    check("rst stall_cnt", stall_cnt, 32'h0);
`endif

    // T1: forwarding on SrcA, Memory beats Writeback
    Match_1E_M = 1'b1; RegWriteM = 1'b1; Match_1E_W = 1'b1; RegWriteW = 1'b1;
    #1;
    check("T1 AE M over W", 32'(ForwardAE), 32'h2);
    check("T1 BE idle", 32'(ForwardBE), 32'h0);
    RegWriteM = 1'b0;
    #1;
    check("T1 AE W", 32'(ForwardAE), 32'h1);
    Match_1E_W = 1'b0;
    #1;
    check("T1 AE none", 32'(ForwardAE), 32'h0);

    // T2: forwarding on SrcB, and the stall-only build
    clr_inputs();
    Match_2E_M = 1'b1;
    #1;
    check("T2 BE no RegWriteM", 32'(ForwardBE), 32'h0);
    RegWriteM = 1'b1; Match_2E_W = 1'b1; RegWriteW = 1'b1;
    #1;
    check("T2 BE M over W", 32'(ForwardBE), 32'h2);
    check("T2 AE unaffected", 32'(ForwardAE), 32'h0);
    Match_2E_M = 1'b0;
    #1;
    check("T2 BE W", 32'(ForwardBE), 32'h1);
    Match_1E_M = 1'b1; Match_1E_W = 1'b1; Match_2E_M = 1'b1;
    #1;
    check("T2 nofwd AE", 32'(nf_fwd_a), 32'h0);
    check("T2 nofwd BE", 32'(nf_fwd_b), 32'h0);
    check("T2 fwd AE", 32'(ForwardAE), 32'h2);

    // T3: one-cycle load-use stall
    clr_inputs();
    tick();
    Match_12D_E = 1'b1; MemtoRegE = 1'b1;
    #1;
    check("T3 ldr ctl", 32'(ctl), 32'b1101);
    check("T3 only one match", 32'(ctl), 32'b1101);
    Match_12D_E = 1'b0;
    #1;
    check("T3 no match ctl", 32'(ctl), 32'b0000);
    Match_12D_E = 1'b1; PCSrcD = 1'b1;
    #1;
    check("T3 stalled PC writer ctl", 32'(ctl), 32'b1101);
    tick();
    clr_inputs();
    #1;
    check("T3 after ldr ctl", 32'(ctl), 32'b0000);

    // T4: R15 write tracked through E, M, W
    PCSrcD = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("T4 ctl cycle %0d", i), 32'(ctl), 32'(t4_ctl[i]));
      tick();
      clr_inputs();
      #1;
    end

    // T4b: PC writer seen in PC_W is ignored by the tracker
    PCSrcD = 1'b1;
    tick();
    clr_inputs();
    tick();
    tick();
    PCSrcD = 1'b1;
    #1;
    check("T4b PC_W with PCSrcD ctl", 32'(ctl), 32'b1010);
    tick();
    clr_inputs();
    #1;
    check("T4b back to IDLE ctl", 32'(ctl), 32'b0000);

    // T5: branch squashes a PC writer in Decode
    PCSrcD = 1'b1; BranchTakenE = 1'b1;
    #1;
    check("T5 ctl", 32'(ctl), 32'b0011);
    tick();
    clr_inputs();
    #1;
    check("T5 stays IDLE ctl", 32'(ctl), 32'b0000);

    // Illegal overlap: branch wins over load-use hold of Decode
    Match_12D_E = 1'b1; MemtoRegE = 1'b1; BranchTakenE = 1'b1;
    #1;
    check("illegal ctl", 32'(ctl), 32'b1011);
    tick();
    clr_inputs();
    #1;

    // T6: reset while in PC_M
    PCSrcD = 1'b1;
    tick();
    clr_inputs();
    tick();
    #1;
    check("T6 PC_M ctl", 32'(ctl), 32'b1010);
    reset = 1'b1;
    #1;
    check("T6 in reset ctl", 32'(ctl), 32'b0011);
    tick();
    reset = 1'b0;
    #1;
    check("T6 after reset ctl", 32'(ctl), 32'b0000);
    tick();
    #1;
    check("T6 still IDLE ctl", 32'(ctl), 32'b0000);
`ifdef HAZARD_PERF_EN
    check("T6 stall_cnt", stall_cnt, 32'h0);
    check("T6 flush_cnt", flush_cnt, 32'h0);
    check("T6 ldr_cnt", ldr_cnt, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
